// File: rtl/axis_broadcaster_1to2.sv
// axis_broadcaster_1to2: AXI4-Stream 1-to-2 broadcaster.
// Each accepted slave beat is copied into one output slot per master port.
// The two ports drain independently. A new beat is taken only when both
// slots can accept it, either because they are empty or because they are
// draining in the same cycle.
module axis_broadcaster_1to2 #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  AXIS_ACLK,
    input  logic                  AXIS_ARESETN,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TVALID,
    input  logic                  S_AXIS_TLAST,
    output logic                  S_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA1,
    output logic                  M_AXIS_TVALID1,
    output logic                  M_AXIS_TLAST1,
    input  logic                  M_AXIS_TREADY1,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA2,
    output logic                  M_AXIS_TVALID2,
    output logic                  M_AXIS_TLAST2,
    input  logic                  M_AXIS_TREADY2
);

    localparam int NUM_PORTS = 2;

    logic [NUM_PORTS-1:0]                 vld;
    logic [NUM_PORTS-1:0]                 rdy;
    logic [NUM_PORTS-1:0]                 free;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] data;
    logic [NUM_PORTS-1:0]                 last;
    logic                                 accept;

    assign rdy = {M_AXIS_TREADY2, M_AXIS_TREADY1};

    // A slot is free if it is empty or is being drained on this edge.
    assign free          = ~vld | rdy;
    assign S_AXIS_TREADY = AXIS_ARESETN & (&free);
    assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        // Output slot: a slave accept (re)loads the slot, and a drain empties it.
        // The payload is left in place after a drain and is only overwritten
        // by the next accepted beat.
        always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
            if (!AXIS_ARESETN) begin
                vld[p]  <= 1'b0;
                data[p] <= '0;
                last[p] <= 1'b0;
            end else if (accept) begin
                vld[p]  <= 1'b1;
                data[p] <= S_AXIS_TDATA;
                last[p] <= S_AXIS_TLAST;
            end else if (rdy[p]) begin
                vld[p]  <= 1'b0;
            end
        end
    end

    assign M_AXIS_TDATA1  = data[0];
    assign M_AXIS_TVALID1 = vld[0];
    assign M_AXIS_TLAST1  = last[0];
    assign M_AXIS_TDATA2  = data[1];
    assign M_AXIS_TVALID2 = vld[1];
    assign M_AXIS_TLAST2  = last[1];

endmodule

// File: tb/tb_axis_broadcaster_1to2.sv
// Directed and randomized-backpressure bench for axis_broadcaster_1to2.
// The bench includes a scoreboard and an always-on protocol monitor, and it
// samples all handshakes on the falling clock edge.
module tb_axis_broadcaster_1to2;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata1, m_tdata2;
    logic          m_tvalid1, m_tvalid2;
    logic          m_tlast1, m_tlast2;
    logic          m_tready1 = 1'b0;
    logic          m_tready2 = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    axis_broadcaster_1to2 #(.DATA_WIDTH(DW)) dut (
        .AXIS_ACLK      (clk),
        .AXIS_ARESETN   (rst_n),
        .S_AXIS_TDATA   (s_tdata),
        .S_AXIS_TVALID  (s_tvalid),
        .S_AXIS_TLAST   (s_tlast),
        .S_AXIS_TREADY  (s_tready),
        .M_AXIS_TDATA1  (m_tdata1),
        .M_AXIS_TVALID1 (m_tvalid1),
        .M_AXIS_TLAST1  (m_tlast1),
        .M_AXIS_TREADY1 (m_tready1),
        .M_AXIS_TDATA2  (m_tdata2),
        .M_AXIS_TVALID2 (m_tvalid2),
        .M_AXIS_TLAST2  (m_tlast2),
        .M_AXIS_TREADY2 (m_tready2)
    );

    // ---------------- scoreboard: every beat once per port, in order
    logic [DW:0] q1[$];
    logic [DW:0] q2[$];
    int          outs1 = 0;
    int          outs2 = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
            q2.delete();
        end else begin
            if (m_tvalid1 && m_tready1) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++;
                    $display("FAIL sb_port1: unexpected beat %h", m_tdata1);
                end else begin
                    if ({m_tlast1, m_tdata1} !== q1[0]) begin
                        errors++;
                        $display("FAIL sb_port1: got %h want %h", {m_tlast1, m_tdata1}, q1[0]);
                    end
                    void'(q1.pop_front());
                end
                outs1++;
            end
            if (m_tvalid2 && m_tready2) begin
                checks++;
                if (q2.size() == 0) begin
                    errors++;
                    $display("FAIL sb_port2: unexpected beat %h", m_tdata2);
                end else begin
                    if ({m_tlast2, m_tdata2} !== q2[0]) begin
                        errors++;
                        $display("FAIL sb_port2: got %h want %h", {m_tlast2, m_tdata2}, q2[0]);
                    end
                    void'(q2.pop_front());
                end
                outs2++;
            end
            if (s_tvalid && s_tready) begin
                q1.push_back({s_tlast, s_tdata});
                q2.push_back({s_tlast, s_tdata});
            end
        end
    end

    // ---------------- protocol monitor: hold while stalled, no silent drop
    logic          pv1 = 0, pv2 = 0, pr1 = 0, pr2 = 0, pl1 = 0, pl2 = 0;
    logic [DW-1:0] pd1 = '0, pd2 = '0;
    logic          rst_seen = 1'b1;

    always @(negedge rst_n) rst_seen = 1'b1;

    always @(negedge clk) begin
        if (rst_n && !rst_seen) begin
            if (pv1 && !pr1) begin
                checks++;
                if (!m_tvalid1 || m_tdata1 !== pd1 || m_tlast1 !== pl1) begin
                    errors++;
                    $display("FAIL proto_port1: v=%b d=%h l=%b held d=%h l=%b", m_tvalid1, m_tdata1, m_tlast1, pd1, pl1);
                end
            end
            if (pv2 && !pr2) begin
                checks++;
                if (!m_tvalid2 || m_tdata2 !== pd2 || m_tlast2 !== pl2) begin
                    errors++;
                    $display("FAIL proto_port2: v=%b d=%h l=%b held d=%h l=%b", m_tvalid2, m_tdata2, m_tlast2, pd2, pl2);
                end
            end
        end
        rst_seen = !rst_n;
        pv1 = m_tvalid1; pr1 = m_tready1; pd1 = m_tdata1; pl1 = m_tlast1;
        pv2 = m_tvalid2; pr2 = m_tready2; pd2 = m_tdata2; pl2 = m_tlast2;
    end

    // ---------------- tests
    task automatic test_reset();
        rst_n = 1'b0;
        m_tready1 = 1'b1;
        m_tready2 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_tvalid1, m_tvalid2, m_tlast1, m_tlast2, s_tready} !== 5'b0 ||
            m_tdata1 !== '0 || m_tdata2 !== '0) begin
            errors++;
            $display("FAIL reset_state: v=%b%b l=%b%b rdy=%b d1=%h d2=%h",
                     m_tvalid1, m_tvalid2, m_tlast1, m_tlast2, s_tready, m_tdata1, m_tdata2);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", s_tready);
        end
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        s_tvalid = 1'b1; s_tdata = 32'h00ABCDEF; s_tlast = 1'b0;
        @(posedge clk); #1;
        s_tdata = 32'h00123456; s_tlast = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_tvalid1, m_tvalid2} !== 2'b11 || m_tdata1 !== 32'h00ABCDEF ||
            m_tdata2 !== 32'h00ABCDEF || {m_tlast1, m_tlast2} !== 2'b00) begin
            errors++;
            $display("FAIL basic_beat0: v=%b%b d1=%h d2=%h l=%b%b want 11 00abcdef 00",
                     m_tvalid1, m_tvalid2, m_tdata1, m_tdata2, m_tlast1, m_tlast2);
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_tvalid1, m_tvalid2} !== 2'b11 || m_tdata1 !== 32'h00123456 ||
            m_tdata2 !== 32'h00123456 || {m_tlast1, m_tlast2} !== 2'b11) begin
            errors++;
            $display("FAIL basic_beat1: v=%b%b d1=%h d2=%h l=%b%b want 11 00123456 11",
                     m_tvalid1, m_tvalid2, m_tdata1, m_tdata2, m_tlast1, m_tlast2);
        end
        @(negedge clk);
        checks++;
        if ({m_tvalid1, m_tvalid2} !== 2'b00) begin
            errors++;
            $display("FAIL basic_drain: v=%b%b want 00", m_tvalid1, m_tvalid2);
        end
    endtask

    task automatic test_stall();
        @(posedge clk); #1;
        m_tready1 = 1'b0; m_tready2 = 1'b1;
        s_tvalid = 1'b1; s_tdata = 32'hDEADBEEF; s_tlast = 1'b0;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_tvalid1, m_tvalid2} !== 2'b11 || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL stall_load: v=%b%b rdy=%b want 11 0", m_tvalid1, m_tvalid2, s_tready);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (m_tvalid1 !== 1'b1 || m_tvalid2 !== 1'b0 || m_tdata1 !== 32'hDEADBEEF || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold: v=%b%b d1=%h rdy=%b want 10 deadbeef 0",
                     m_tvalid1, m_tvalid2, m_tdata1, s_tready);
        end
        @(posedge clk); #1;
        m_tready1 = 1'b1;
        #1;
        checks++;
        if (s_tready !== 1'b1 || m_tvalid1 !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: rdy=%b v1=%b want 1 1", s_tready, m_tvalid1);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({m_tvalid1, m_tvalid2} !== 2'b00) begin
            errors++;
            $display("FAIL stall_drain: v=%b%b want 00", m_tvalid1, m_tvalid2);
        end
    endtask

    task automatic test_random();
        int  sent  = 0;
        int  base1 = outs1;
        int  base2 = outs2;
        bit  fire;
        bit  done  = 0;
        s_tvalid = 1'b0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            @(negedge clk);
            fire = s_tvalid && s_tready;
            @(posedge clk); #1;
            if (fire) sent++;
            m_tready1 = 1'($urandom_range(0, 1));
            m_tready2 = 1'($urandom_range(0, 1));
            if (fire || !s_tvalid) begin
                if (sent < 2000 && $urandom_range(0, 3) != 0) begin
                    s_tvalid = 1'b1;
                    s_tdata  = $urandom;
                    s_tlast  = 1'($urandom_range(0, 1));
                end else begin
                    s_tvalid = 1'b0;
                end
            end
            if (sent == 2000 && !s_tvalid && q1.size() == 0 && q2.size() == 0) done = 1;
        end
        s_tvalid = 1'b0;
        m_tready1 = 1'b1;
        m_tready2 = 1'b1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL random_timeout: sent=%0d q1=%0d q2=%0d", sent, q1.size(), q2.size());
        end
        checks++;
        if (outs1 - base1 != 2000 || outs2 - base2 != 2000) begin
            errors++;
            $display("FAIL random_count: port1=%0d port2=%0d want 2000", outs1 - base1, outs2 - base2);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1;
        m_tready1 = 1'b0; m_tready2 = 1'b0;
        s_tvalid = 1'b1; s_tdata = 32'hCAFEF00D; s_tlast = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_tvalid1, m_tvalid2} !== 2'b11 || m_tdata1 !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL areset_preload: v=%b%b d1=%h want 11 cafef00d", m_tvalid1, m_tvalid2, m_tdata1);
        end
        #2;
        m_tready1 = 1'b1; m_tready2 = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({m_tvalid1, m_tvalid2, m_tlast1, m_tlast2, s_tready} !== 5'b0 ||
            m_tdata1 !== '0 || m_tdata2 !== '0) begin
            errors++;
            $display("FAIL areset_immediate: v=%b%b l=%b%b rdy=%b d1=%h d2=%h",
                     m_tvalid1, m_tvalid2, m_tlast1, m_tlast2, s_tready, m_tdata1, m_tdata2);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b1; s_tdata = 32'h55AA55AA; s_tlast = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_tvalid1, m_tvalid2} !== 2'b11 || m_tdata1 !== 32'h55AA55AA ||
            m_tdata2 !== 32'h55AA55AA || {m_tlast1, m_tlast2} !== 2'b11) begin
            errors++;
            $display("FAIL areset_first_beat: v=%b%b d1=%h d2=%h l=%b%b want 11 55aa55aa 11",
                     m_tvalid1, m_tvalid2, m_tdata1, m_tdata2, m_tlast1, m_tlast2);
        end
        @(negedge clk);
    endtask

    task automatic test_sparse();
        logic [DW-1:0] d;
        m_tready1 = 1'b1; m_tready2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = 32'h1000_0000 + 32'(i * 32'h0101);
            @(posedge clk); #1;
            s_tvalid = 1'b1; s_tdata = d; s_tlast = 1'(i & 1);
            @(posedge clk); #1;
            s_tvalid = 1'b0;
            @(negedge clk);
            checks++;
            if ({m_tvalid1, m_tvalid2} !== 2'b11 || m_tdata1 !== d || m_tdata2 !== d ||
                m_tlast1 !== 1'(i & 1) || m_tlast2 !== 1'(i & 1)) begin
                errors++;
                $display("FAIL sparse_beat%0d: v=%b%b d1=%h d2=%h want %h", i, m_tvalid1, m_tvalid2, m_tdata1, m_tdata2, d);
            end
            @(negedge clk);
            checks++;
            if ({m_tvalid1, m_tvalid2} !== 2'b00) begin
                errors++;
                $display("FAIL sparse_gap%0d: v=%b%b want 00", i, m_tvalid1, m_tvalid2);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int base1 = outs1;
        int base2 = outs2;
        m_tready1 = 1'b1; m_tready2 = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            s_tvalid = 1'b1; s_tdata = 32'hB000_0000 | 32'(i); s_tlast = 1'(i == 15);
            @(negedge clk);
            checks++;
            if (s_tready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: got %b want 1", i, s_tready);
            end
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (outs1 - base1 != 16 || outs2 - base2 != 16) begin
            errors++;
            $display("FAIL b2b_count: port1=%0d port2=%0d want 16", outs1 - base1, outs2 - base2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_random();
        test_async_reset();
        test_sparse();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
